// File: rtl/data_sram_responder.sv
// Single-port 128x32 data SRAM for the processor. After reset it zeroes itself
// word by word, then serves processor reads and writes. A preload port may
// write the array in any RUN cycle where the processor is not selecting it.
module data_sram_responder #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [6:0]       A,
  input  logic [31:0]      D,
  output logic [31:0]      Q,
  output logic             busy,
  input  logic             ld_valid,
  input  logic [6:0]       ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

  state_t      state, state_d;
  logic [6:0]  clr_ptr, clr_ptr_d;
  logic [31:0] mem [DEPTH];

  logic        proc_rd;
  logic        proc_wr;
  logic        ld_fire;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;

  // Processor access decode; CEN gates both, and WEN picks read or write
  assign proc_rd  = (state == RUN) && !CEN && WEN && !OEN;
  assign proc_wr  = (state == RUN) && !CEN && !WEN;
  assign ld_ready = (state == RUN) && CEN;
  assign ld_fire  = ld_valid && ld_ready;
  assign Q        = proc_rd ? mem[A] : 32'h0;

  // Next-state logic and the single write-port mux (clear, processor, preload)
  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    mem_we    = 1'b0;
    mem_waddr = A;
    mem_wdata = D;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = 32'h0;
        clr_ptr_d = clr_ptr + 7'd1;
        if (clr_ptr == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (proc_wr) begin
          mem_we    = 1'b1;
          mem_waddr = A;
          mem_wdata = D;
        end else if (ld_fire) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State, clear pointer and busy flag; busy is a registered copy of CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= 7'd0;
      busy    <= 1'b1;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
      busy    <= (state_d == CLEAR);
    end
  end

  // Array write; suppressed on any edge taken while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Saturating access counters; preload traffic is deliberately not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (proc_rd && (rd_cnt != '1)) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (proc_wr && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

endmodule
